// File: rtl/pcie_us_cfg_resp.sv
// Simulation-side responder for the UltraScale PCIe cfg_mgmt port: ID, Device Capabilities and Device Control per function.
// Define PCIE_US_CFG_RESP_FLR_EN so a Device Control write with bit 15 set triggers a function-level reset.
module pcie_us_cfg_resp #(
  parameter int          PF_COUNT        = 1,
  parameter int          VF_COUNT        = 0,
  parameter int          VF_OFFSET       = 64,
  parameter int          F_COUNT         = PF_COUNT + VF_COUNT,
  parameter logic [11:0] PCIE_CAP_OFFSET = 12'h0C0,
  parameter logic [31:0] ID_DWORD        = 32'h1001_1234,
  parameter logic [31:0] DEV_CAP         = 32'h0000_8022,
  parameter logic [15:0] DEV_CTRL_RESET  = 16'h2810,
  parameter logic [15:0] DEV_CTRL_WMASK  = 16'h7FFF,
  parameter int          RESP_LATENCY    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [9:0]             cfg_mgmt_addr,
  input  logic [7:0]             cfg_mgmt_function_number,
  input  logic                   cfg_mgmt_write,
  input  logic [31:0]            cfg_mgmt_write_data,
  input  logic [3:0]             cfg_mgmt_byte_enable,
  input  logic                   cfg_mgmt_read,
  output logic [31:0]            cfg_mgmt_read_data,
  output logic                   cfg_mgmt_read_write_done,
  output logic [F_COUNT*16-1:0]  dev_ctrl,
  output logic [F_COUNT-1:0]     flr_pulse
);
  localparam logic [11:0] CAP_BYTE  = PCIE_CAP_OFFSET + 12'd4;
  localparam logic [11:0] CTRL_BYTE = PCIE_CAP_OFFSET + 12'd8;
  localparam logic [9:0]  CAP_ADDR  = CAP_BYTE[11:2];
  localparam logic [9:0]  CTRL_ADDR = CTRL_BYTE[11:2];
  localparam logic [8:0]  PF_END    = 9'(PF_COUNT);
  localparam logic [8:0]  VF_LO     = 9'(VF_OFFSET);
  localparam logic [8:0]  VF_HI     = 9'(VF_OFFSET + VF_COUNT);
  // Bit 15 is never stored so it always reads back as 0.
  localparam logic [15:0] WMASK     = DEV_CTRL_WMASK & 16'h7FFF;
  localparam logic [15:0] RST_VAL   = DEV_CTRL_RESET & 16'h7FFF;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_GAP} state_e;
  state_e state_q, state_d;

  logic [7:0]  cnt_q, cnt_d;
  logic [9:0]  addr_q;
  logic [7:0]  fn_q;
  logic [15:0] wdata_q;
  logic [1:0]  be_q;
  logic        wr_q;
  logic [31:0] rdata_q, rdata_d;
  logic [F_COUNT-1:0][15:0] dev_ctrl_q, dev_ctrl_d;
  logic [F_COUNT-1:0]       flr_q, flr_d;

  logic        req, enter_done, commit, flr_hit, fvalid;
  logic [5:0]  idx;
  logic [8:0]  fn9;
  logic [15:0] sel_dc, wmask;
  logic        unused_in;

  assign unused_in  = ^{cfg_mgmt_write_data[31:16], cfg_mgmt_byte_enable[3:2]};
  assign req        = cfg_mgmt_write | cfg_mgmt_read;
  assign enter_done = (state_q == S_BUSY) && (cnt_q == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = S_BUSY;
      S_BUSY:  if (cnt_q == 8'd0) state_d = S_DONE;
      S_DONE:  state_d = S_GAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cfg_mgmt_read_write_done = (state_q == S_DONE);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE && req)             cnt_d = 8'(RESP_LATENCY - 1);
    else if (state_q == S_BUSY && cnt_q != 0) cnt_d = cnt_q - 8'd1;
  end

  // Map the captured function number onto a dense storage index.
  always_comb begin
    fn9    = {1'b0, fn_q};
    idx    = 6'd0;
    fvalid = 1'b0;
    if (fn9 < PF_END) begin
      idx    = fn_q[5:0];
      fvalid = 1'b1;
    end else if (fn9 >= VF_LO && fn9 < VF_HI) begin
      idx    = 6'(fn9 - VF_LO + PF_END);
      fvalid = 1'b1;
    end
  end

  always_comb begin
    sel_dc = 16'h0;
    for (int i = 0; i < F_COUNT; i++)
      if (idx == 6'(i)) sel_dc = dev_ctrl_q[i];
    rdata_d = 32'h0;
    if (fvalid) begin
      if (addr_q == 10'd0)          rdata_d = ID_DWORD;
      else if (addr_q == CAP_ADDR)  rdata_d = DEV_CAP;
      else if (addr_q == CTRL_ADDR) rdata_d = {16'h0, sel_dc};
    end
  end

  assign wmask  = {{8{be_q[1]}}, {8{be_q[0]}}} & WMASK;
  assign commit = enter_done && wr_q && fvalid && (addr_q == CTRL_ADDR);
`ifdef PCIE_US_CFG_RESP_FLR_EN
  assign flr_hit = commit && wdata_q[15] && be_q[1];
`else
  assign flr_hit = 1'b0;
`endif

  always_comb begin
    dev_ctrl_d = dev_ctrl_q;
    flr_d      = '0;
    for (int i = 0; i < F_COUNT; i++) begin
      if (commit && idx == 6'(i)) begin
        dev_ctrl_d[i] = flr_hit ? RST_VAL : ((dev_ctrl_q[i] & ~wmask) | (wdata_q & wmask));
        flr_d[i]      = flr_hit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= 8'd0;
      addr_q     <= 10'd0;
      fn_q       <= 8'd0;
      wdata_q    <= 16'h0;
      be_q       <= 2'b00;
      wr_q       <= 1'b0;
      rdata_q    <= 32'h0;
      dev_ctrl_q <= {F_COUNT{RST_VAL}};
      flr_q      <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (state_q == S_IDLE && req) begin
        addr_q  <= cfg_mgmt_addr;
        fn_q    <= cfg_mgmt_function_number;
        wdata_q <= cfg_mgmt_write_data[15:0];
        be_q    <= cfg_mgmt_byte_enable[1:0];
        wr_q    <= cfg_mgmt_write;
      end
      if (enter_done && !wr_q) rdata_q <= rdata_d;
      dev_ctrl_q <= dev_ctrl_d;
      flr_q      <= flr_d;
    end
  end

  assign cfg_mgmt_read_data = rdata_q;
  assign dev_ctrl           = dev_ctrl_q;
  assign flr_pulse          = flr_q;
endmodule
